// File: rtl/matmul_pkg.sv
// matmul_pkg
// Shared types and helpers for the matrix-multiply engine:
//   state_t   - engine FSM state encoding
//   acc_width - exact accumulator width for DATA_WIDTH operands summed MAX_DIM times
//   sat_max / sat_min - clamp limits of the narrowed result for a given mode
package matmul_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic int acc_width(input int dw, input int max_dim);
    return 2 * dw + $clog2(max_dim);
  endfunction

  function automatic int sat_max(input int dw, input logic sgn);
    if (sgn) return (1 << (dw - 1)) - 1;
    return (1 << dw) - 1;
  endfunction

  function automatic int sat_min(input int dw, input logic sgn);
    if (sgn) return -(1 << (dw - 1));
    return 0;
  endfunction

endpackage

// File: rtl/matmul_if.sv
// matmul_if
// Control handshake plus the A/B read ports and C write port of the engine.
//   control : start, dim, signed_mode -> busy, done, cfg_err, ovf_any
//   A/B read: en_ReadMat_*, rowAddr_*, colAddr_* out; readData_* in (1-cycle latency)
//   C write : en_WriteMat_C, rowAddr_C, colAddr_C, writeData_C, result_sat out
// master = engine side, slave = environment (controller + memories) side.
interface matmul_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) ();

  logic                  start;
  logic [ADDR_WIDTH:0]   dim;
  logic                  signed_mode;
  logic                  busy;
  logic                  done;
  logic                  cfg_err;
  logic                  ovf_any;

  logic                  en_ReadMat_A;
  logic                  en_ReadMat_B;
  logic [ADDR_WIDTH-1:0] rowAddr_A;
  logic [ADDR_WIDTH-1:0] colAddr_A;
  logic [ADDR_WIDTH-1:0] rowAddr_B;
  logic [ADDR_WIDTH-1:0] colAddr_B;
  logic [DATA_WIDTH-1:0] readData_A;
  logic [DATA_WIDTH-1:0] readData_B;

  logic                  en_WriteMat_C;
  logic [ADDR_WIDTH-1:0] rowAddr_C;
  logic [ADDR_WIDTH-1:0] colAddr_C;
  logic [DATA_WIDTH-1:0] writeData_C;
  logic                  result_sat;

  modport master (
    input  start, dim, signed_mode, readData_A, readData_B,
    output busy, done, cfg_err, ovf_any,
    output en_ReadMat_A, en_ReadMat_B, rowAddr_A, colAddr_A, rowAddr_B, colAddr_B,
    output en_WriteMat_C, rowAddr_C, colAddr_C, writeData_C, result_sat
  );

  modport slave (
    output start, dim, signed_mode, readData_A, readData_B,
    input  busy, done, cfg_err, ovf_any,
    input  en_ReadMat_A, en_ReadMat_B, rowAddr_A, colAddr_A, rowAddr_B, colAddr_B,
    input  en_WriteMat_C, rowAddr_C, colAddr_C, writeData_C, result_sat
  );

endinterface

// File: rtl/matmul_mac_sat.sv
// mac_sat
// Accumulator for one C element with signed/unsigned multiply-add and a
// combinational saturating narrow to DATA_WIDTH.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_signed       : operand/result interpretation
//   i_clr          : clear accumulator (wins over i_acc_en)
//   i_acc_en       : add i_a * i_b this cycle
//   i_a, i_b       : operands
//   o_data, o_sat  : narrowed accumulator and clamp flag
module mac_sat
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_signed,
  input  logic                  i_clr,
  input  logic                  i_acc_en,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sat
);

  localparam int ACC_W = acc_width(DATA_WIDTH, MAX_DIM);

  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(sat_max(DATA_WIDTH, 1'b1));
  localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(sat_min(DATA_WIDTH, 1'b1));
  localparam logic [ACC_W-1:0]        U_MAX = ACC_W'(sat_max(DATA_WIDTH, 1'b0));

  localparam logic [DATA_WIDTH-1:0] D_SMAX = DATA_WIDTH'(sat_max(DATA_WIDTH, 1'b1));
  localparam logic [DATA_WIDTH-1:0] D_SMIN = DATA_WIDTH'(sat_min(DATA_WIDTH, 1'b1));
  localparam logic [DATA_WIDTH-1:0] D_UMAX = DATA_WIDTH'(sat_max(DATA_WIDTH, 1'b0));

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_a_ext;
  logic [ACC_W-1:0] w_b_ext;
  logic [ACC_W-1:0] w_prod;
  logic             w_hi;
  logic             w_lo;

  // Extending to ACC_W first makes the truncated product correct in both
  // modes: the low ACC_W bits of a two's-complement product do not depend on
  // how the operands are interpreted once they are sign/zero extended.
  assign w_a_ext = {{(ACC_W-DATA_WIDTH){i_signed & i_a[DATA_WIDTH-1]}}, i_a};
  assign w_b_ext = {{(ACC_W-DATA_WIDTH){i_signed & i_b[DATA_WIDTH-1]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge i_clk) begin
    if (i_reset)       r_acc <= '0;
    else if (i_clr)    r_acc <= '0;
    else if (i_acc_en) r_acc <= r_acc + w_prod;
  end

  // Unsigned sums can use the top accumulator bit, so the range test must
  // follow the mode rather than always compare signed.
  always_comb begin
    w_hi   = 1'b0;
    w_lo   = 1'b0;
    o_data = r_acc[DATA_WIDTH-1:0];
    if (i_signed) begin
      w_hi = $signed(r_acc) > S_MAX;
      w_lo = $signed(r_acc) < S_MIN;
      if (w_hi)      o_data = D_SMAX;
      else if (w_lo) o_data = D_SMIN;
    end else begin
      w_hi = r_acc > U_MAX;
      if (w_hi) o_data = D_UMAX;
    end
    o_sat = w_hi | w_lo;
  end

endmodule

// File: rtl/matmul_engine.sv
// matmul_engine
// C = A x B for square matrices of runtime dimension 1..MAX_DIM, reading A/B
// from 1-cycle-latency memories and writing saturated C elements row-major.
//   i_clk, i_reset : clock, synchronous active-high reset
//   io_bus         : matmul_if.master (control handshake, A/B read, C write)
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; latches dim/mode, clears indices and flags
// S_READ  | strobing A[i][k], B[k][j]; accumulating previous cycle's data
// S_DRAIN | accumulating the last product of the current element
// S_WRITE | writing saturated C[i][j]; advancing j then i
// S_DONE  | one-cycle done (with cfg_err for a bad dim)
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 10,
  parameter int ADDR_WIDTH = 4
) (
  input  logic     i_clk,
  input  logic     i_reset,
  matmul_if.master io_bus
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_dim;
  logic                  r_signed;
  logic [ADDR_WIDTH-1:0] r_i;
  logic [ADDR_WIDTH-1:0] r_j;
  logic [ADDR_WIDTH-1:0] r_k;
  logic                  r_en_rd;
  logic                  r_en_wr;
  logic                  r_rd_vld;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cfg_err;
  logic                  r_ovf;

  logic [ADDR_WIDTH:0]   w_dim_m1;
  logic                  w_start_acc;
  logic                  w_dim_ok;
  logic                  w_k_last;
  logic                  w_j_last;
  logic                  w_i_last;
  logic                  w_en_rd_nxt;
  logic                  w_en_wr_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_cfg_err_nxt;
  logic                  w_acc_clr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_sat;

  assign w_start_acc = (r_state == S_IDLE) && io_bus.start;
  assign w_dim_ok    = (io_bus.dim != '0) && (io_bus.dim <= (ADDR_WIDTH+1)'(MAX_DIM));
  assign w_dim_m1    = r_dim - (ADDR_WIDTH+1)'(1);
  assign w_k_last    = ({1'b0, r_k} == w_dim_m1);
  assign w_j_last    = ({1'b0, r_j} == w_dim_m1);
  assign w_i_last    = ({1'b0, r_i} == w_dim_m1);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.start) w_state_nxt = w_dim_ok ? S_READ : S_DONE;
      S_READ:  if (w_k_last) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = (w_i_last && w_j_last) ? S_DONE : S_READ;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes and status are registered, so they are derived from the state
  // being entered rather than the current one.
  always_comb begin
    w_en_rd_nxt   = (w_state_nxt == S_READ);
    w_en_wr_nxt   = (w_state_nxt == S_WRITE);
    w_busy_nxt    = w_en_rd_nxt || w_en_wr_nxt || (w_state_nxt == S_DRAIN);
    w_done_nxt    = (w_state_nxt == S_DONE);
    w_cfg_err_nxt = w_start_acc && !w_dim_ok;
    w_acc_clr     = w_start_acc || (r_state == S_WRITE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dim     <= '0;
      r_signed  <= 1'b0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_en_rd   <= 1'b0;
      r_en_wr   <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_en_rd   <= w_en_rd_nxt;
      r_en_wr   <= w_en_wr_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_cfg_err <= w_cfg_err_nxt;
      // Data requested by this cycle's strobe is on readData next cycle.
      r_rd_vld  <= r_en_rd;
      if (w_start_acc) begin
        r_dim    <= io_bus.dim;
        r_signed <= io_bus.signed_mode;
        r_i      <= '0;
        r_j      <= '0;
        r_k      <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (r_en_wr && w_sat) r_ovf <= 1'b1;
        case (r_state)
          S_READ: r_k <= w_k_last ? '0 : r_k + ADDR_WIDTH'(1);
          S_WRITE: begin
            if (w_j_last) begin
              r_j <= '0;
              r_i <= w_i_last ? '0 : r_i + ADDR_WIDTH'(1);
            end else begin
              r_j <= r_j + ADDR_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  mac_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_DIM    (MAX_DIM)
  ) u_mac_sat (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_signed (r_signed),
    .i_clr    (w_acc_clr),
    .i_acc_en (r_rd_vld),
    .i_a      (io_bus.readData_A),
    .i_b      (io_bus.readData_B),
    .o_data   (w_data),
    .o_sat    (w_sat)
  );

  assign io_bus.busy          = r_busy;
  assign io_bus.done          = r_done;
  assign io_bus.cfg_err       = r_cfg_err;
  assign io_bus.ovf_any       = r_ovf;
  assign io_bus.en_ReadMat_A  = r_en_rd;
  assign io_bus.en_ReadMat_B  = r_en_rd;
  assign io_bus.rowAddr_A     = r_i;
  assign io_bus.colAddr_A     = r_k;
  assign io_bus.rowAddr_B     = r_k;
  assign io_bus.colAddr_B     = r_j;
  assign io_bus.en_WriteMat_C = r_en_wr;
  assign io_bus.rowAddr_C     = r_i;
  assign io_bus.colAddr_C     = r_j;
  assign io_bus.writeData_C   = w_data;
  assign io_bus.result_sat    = w_sat & r_en_wr;

endmodule

// File: tb/tb_matmul_engine.sv
// tb_matmul_engine
// Drives matmul_engine with directed and random matrices; an array-based
// reference computes every C element with plain integer sums and clamping.
module tb_matmul_engine;

  localparam int DW = 8;
  localparam int MD = 10;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  matmul_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  matmul_engine #(
    .DATA_WIDTH (DW),
    .MAX_DIM    (MD),
    .ADDR_WIDTH (AW)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  logic [DW-1:0] mem_a [MD][MD];
  logic [DW-1:0] mem_b [MD][MD];

  int           n_chk = 0;
  int           n_fail = 0;
  logic [16:0]  wr_q[$];
  logic [16:0]  exp_q[$];
  bit           exp_ovf;
  int           n_rd = 0;
  int           n_addr_bad = 0;
  int           cur_dim = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memories: registered read, garbage when not strobed so stray use of
  // readData shows up as a wrong result.
  always @(posedge clk) begin
    if (bus.en_ReadMat_A && int'(bus.rowAddr_A) < MD && int'(bus.colAddr_A) < MD)
      bus.readData_A <= mem_a[bus.rowAddr_A][bus.colAddr_A];
    else
      bus.readData_A <= DW'($urandom);
    if (bus.en_ReadMat_B && int'(bus.rowAddr_B) < MD && int'(bus.colAddr_B) < MD)
      bus.readData_B <= mem_b[bus.rowAddr_B][bus.colAddr_B];
    else
      bus.readData_B <= DW'($urandom);
  end

  always @(negedge clk) begin
    if (bus.en_WriteMat_C)
      wr_q.push_back({bus.rowAddr_C, bus.colAddr_C, bus.writeData_C, bus.result_sat});
    if (bus.en_ReadMat_A) n_rd++;
    if (bus.en_ReadMat_A !== bus.en_ReadMat_B)
      n_addr_bad++;
    else if (bus.en_ReadMat_A &&
             (bus.colAddr_A != bus.rowAddr_B || int'(bus.rowAddr_A) >= cur_dim ||
              int'(bus.colAddr_A) >= cur_dim || int'(bus.colAddr_B) >= cur_dim))
      n_addr_bad++;
  end

  function automatic logic [63:0] outs_all();
    return 64'({bus.busy, bus.done, bus.cfg_err, bus.ovf_any,
                bus.en_ReadMat_A, bus.en_ReadMat_B, bus.en_WriteMat_C, bus.result_sat,
                bus.rowAddr_A, bus.colAddr_A, bus.rowAddr_B, bus.colAddr_B,
                bus.rowAddr_C, bus.colAddr_C, bus.writeData_C});
  endfunction

  task automatic build_exp(input int d, input bit sgn);
    int sum, av, bv, mx, mn;
    bit sat;
    mx = sgn ? 127 : 255;
    mn = sgn ? -128 : 0;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        sum = 0;
        for (int k = 0; k < d; k++) begin
          av = sgn ? int'(byte'(mem_a[i][k])) : int'(mem_a[i][k]);
          bv = sgn ? int'(byte'(mem_b[k][j])) : int'(mem_b[k][j]);
          sum += av * bv;
        end
        sat = 1'b0;
        if (sum > mx) begin sum = mx; sat = 1'b1; end
        if (sum < mn) begin sum = mn; sat = 1'b1; end
        if (sat) exp_ovf = 1'b1;
        exp_q.push_back({4'(i), 4'(j), 8'(sum), sat});
      end
    end
  endtask

  task automatic fill_rand(input int maxv);
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++) begin
        mem_a[i][j] = DW'($urandom_range(0, maxv));
        mem_b[i][j] = DW'($urandom_range(0, maxv));
      end
  endtask

  task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++) begin
        mem_a[i][j] = av;
        mem_b[i][j] = bv;
      end
  endtask

  task automatic run_case(input string tag, input int d, input bit sgn,
                          input int glitch_cyc, input int glitch_dim);
    int cyc, exp_cyc, busy_bad, wr_base, rd_base, bad_base, n_wr;
    bit valid, seen;
    valid = (d >= 1 && d <= MD);
    if (valid) build_exp(d, sgn);
    else begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end
    exp_cyc = valid ? d * d * (d + 2) + 1 : 1;
    @(negedge clk);
    wr_base  = wr_q.size();
    rd_base  = n_rd;
    bad_base = n_addr_bad;
    cur_dim  = d;
    bus.start = 1'b1;
    bus.dim = 5'(d);
    bus.signed_mode = sgn;
    @(negedge clk);
    // Scramble the config inputs once the start has been taken.
    bus.start = 1'b0;
    bus.dim = 5'($urandom);
    bus.signed_mode = ~sgn;
    cyc = 1;
    seen = 1'b0;
    busy_bad = 0;
    while (cyc <= exp_cyc + 20) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (!bus.busy) busy_bad++;
      if (cyc == glitch_cyc) begin
        bus.start = 1'b1;
        bus.dim = 5'(glitch_dim);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_done_seen"}, 64'(seen), 64'(1));
    check_val({tag, "_done_cycle"}, 64'(seen ? cyc : 0), 64'(exp_cyc));
    check_val({tag, "_cfg_err"}, 64'(bus.cfg_err), 64'(!valid));
    check_val({tag, "_ovf_any"}, 64'(bus.ovf_any), 64'(exp_ovf));
    check_val({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
    check_val({tag, "_busy_during"}, 64'(busy_bad), 64'(0));
    n_wr = wr_q.size() - wr_base;
    check_val({tag, "_num_writes"}, 64'(n_wr), 64'(exp_q.size()));
    for (int e = 0; e < exp_q.size() && e < n_wr; e++)
      check_val({tag, "_C"}, 64'(wr_q[wr_base + e]), 64'(exp_q[e]));
    check_val({tag, "_num_reads"}, 64'(n_rd - rd_base), 64'(valid ? d * d * d : 0));
    check_val({tag, "_addr"}, 64'(n_addr_bad - bad_base), 64'(0));
    // A start presented while in DONE must not launch a run.
    bus.start = 1'b1;
    bus.dim = 5'(2);
    @(negedge clk);
    bus.start = 1'b0;
    check_val({tag, "_start_in_done"}, 64'({bus.busy, bus.done, bus.en_ReadMat_A}), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, base;
    bus.start = 1'b0;
    bus.dim = '0;
    bus.signed_mode = 1'b0;
    fill_rand(255);
    repeat (3) @(negedge clk);
    check_val("reset_outs", outs_all(), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    check_val("idle_outs", outs_all(), 64'(0));

    // dim=2 unsigned, B = identity
    fill_const(8'd0, 8'd0);
    mem_a[0][0] = 8'd1; mem_a[0][1] = 8'd2;
    mem_a[1][0] = 8'd3; mem_a[1][1] = 8'd4;
    mem_b[0][0] = 8'd1; mem_b[1][1] = 8'd1;
    run_case("ident", 2, 1'b0, 0, 0);

    fill_const(8'hFE, 8'd3);
    run_case("neg2x3", 3, 1'b1, 0, 0);

    fill_const(8'hFF, 8'hFF);
    run_case("ff_unsigned", 2, 1'b0, 0, 0);
    run_case("ff_signed", 2, 1'b1, 0, 0);

    run_case("dim0", 0, 1'b0, 0, 0);
    run_case("dim11", 11, 1'b1, 0, 0);

    fill_rand(15);
    run_case("rand_d1", 1, 1'b0, 0, 0);
    fill_rand(255);
    run_case("rand_d4s", 4, 1'b1, 0, 0);
    fill_rand(40);
    run_case("rand_d7u", 7, 1'b0, 0, 0);
    fill_rand(255);
    run_case("rand_d10", 10, 1'($urandom), 0, 0);
    for (int r = 0; r < 3; r++) begin
      fill_rand((r == 1) ? 20 : 255);
      run_case("rand_any", $urandom_range(1, MD), 1'($urandom), 0, 0);
    end

    fill_rand(30);
    run_case("glitch", 4, 1'b0, 10, 7);

    // Reset mid-run at cycle 500 of a dim=10 job.
    fill_rand(255);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dim = 5'(10);
    bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_val("rst_busy_before", 64'(bus.busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_outs", outs_all(), 64'(0));
    base = wr_q.size();
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_val("rst_no_writes", 64'(wr_q.size() - base), 64'(0));
    check_val("rst_idle", 64'({bus.busy, bus.done}), 64'(0));
    run_case("after_rst", 10, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
